// File: rtl/FPU_192_Package.sv
// Shared FPU_192 types and constants, including those used by the FP-to-decimal
// digit serializer.
package FPU_192_Package;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV_INT,
    CONV_FRAC,
    DONE
  } fp2d_ser_state_t;

  localparam int INT_BITS       = 9;
  localparam int FRAC_BITS      = 23;
  localparam int INT_BCD_DIGITS = 3;

endpackage

// File: rtl/fp2d_mul10.sv
// Combinational multiply-by-ten of a binary fraction: the integer overflow is the
// next decimal digit and the low bits are the remaining fraction.
module fp2d_mul10
  import FPU_192_Package::*;
(
  input  logic [FRAC_BITS-1:0] frac,
  output bcd_digit_t           digit,
  output logic [FRAC_BITS-1:0] frac_next
);

  localparam int PW = FRAC_BITS + 4;

  logic [PW-1:0] add_a;
  logic [PW-1:0] add_b;
  logic [PW-1:0] prod;
  logic          carry;

  // frac*10 = (frac<<3) + (frac<<1), summed bit by bit with a ripple carry
  always_comb begin
    add_a = {1'b0, frac, 3'b000};
    add_b = {3'b000, frac, 1'b0};
    prod  = '0;
    carry = 1'b0;
    for (int i = 0; i < PW; i++) begin
      prod[i] = add_a[i] ^ add_b[i] ^ carry;
      carry   = (add_a[i] & add_b[i]) | (carry & (add_a[i] ^ add_b[i]));
    end
  end

  assign digit     = prod[PW-1 -: 4];
  assign frac_next = prod[FRAC_BITS-1:0];

endmodule

// File: rtl/fp2d_digit_serializer.sv
// Turns the FP-to-decimal converter's binary integer/fraction parts into BCD digits:
// serial double-dabble for the integer, serial multiply-by-ten for the fraction.
module fp2d_digit_serializer
  import FPU_192_Package::*;
#(
  parameter int FRAC_DIGITS = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8:0]               in_left_digit,
  input  logic [22:0]              in_right_digit,
  input  logic                     in_sign,
  input  logic [5:0]               in_exp_10,
  input  logic                     in_sign_exp_10,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [11:0]              out_int_bcd,
  output logic [4*FRAC_DIGITS-1:0] out_frac_bcd,
  output logic [5:0]               out_exp_10,
  output logic                     out_sign_exp_10,
  output logic                     busy
);

  localparam int IW = 4 * INT_BCD_DIGITS;
  localparam int FW = 4 * FRAC_DIGITS;

  // One double-dabble step: correct every nibble >= 5, then shift in the next bit.
  function automatic logic [IW-1:0] dd_step(input logic [IW-1:0] bcd, input logic bin_bit);
    logic [IW-1:0] adj;
    logic [3:0]    nib;
    for (int i = 0; i < INT_BCD_DIGITS; i++) begin
      nib            = bcd[4*i +: 4];
      adj[4*i +: 4]  = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    return {adj[IW-2:0], bin_bit};
  endfunction

  fp2d_ser_state_t        state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [INT_BITS-1:0]    bin_q, bin_d;
  logic [FRAC_BITS-1:0]   frac_q, frac_d;
  logic [IW-1:0]          int_bcd_q, int_bcd_d;
  logic [FW-1:0]          frac_bcd_q, frac_bcd_d;
  logic                   sign_q, sign_d;
  logic [5:0]             exp_q, exp_d;
  logic                   sexp_q, sexp_d;

  bcd_digit_t             mul_digit;
  logic [FRAC_BITS-1:0]   mul_frac_next;

  fp2d_mul10 u_mul10 (
    .frac      (frac_q),
    .digit     (mul_digit),
    .frac_next (mul_frac_next)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    frac_d     = frac_q;
    int_bcd_d  = int_bcd_q;
    frac_bcd_d = frac_bcd_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    sexp_d     = sexp_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d      = in_left_digit;
          frac_d     = in_right_digit;
          sign_d     = in_sign;
          exp_d      = in_exp_10;
          sexp_d     = in_sign_exp_10;
          int_bcd_d  = '0;
          frac_bcd_d = '0;
          cnt_d      = 4'(INT_BITS - 1);
          state_d    = CONV_INT;
        end
      end
      CONV_INT: begin
        int_bcd_d = dd_step(int_bcd_q, bin_q[INT_BITS-1]);
        bin_d     = {bin_q[INT_BITS-2:0], 1'b0};
        if (cnt_q == 4'd0) begin
          cnt_d   = 4'(FRAC_DIGITS - 1);
          state_d = CONV_FRAC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CONV_FRAC: begin
        // New digit enters at the LS end, so the first digit ends up in the MS nibble
        frac_d     = mul_frac_next;
        frac_bcd_d = (frac_bcd_q << 4) | FW'(mul_digit);
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      frac_q     <= '0;
      int_bcd_q  <= '0;
      frac_bcd_q <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      sexp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      frac_q     <= frac_d;
      int_bcd_q  <= int_bcd_d;
      frac_bcd_q <= frac_bcd_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      sexp_q     <= sexp_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = (state_q == DONE);
  assign busy            = (state_q == CONV_INT) || (state_q == CONV_FRAC);
  assign out_sign        = sign_q;
  assign out_int_bcd     = int_bcd_q;
  assign out_frac_bcd    = frac_bcd_q;
  assign out_exp_10      = exp_q;
  assign out_sign_exp_10 = sexp_q;

endmodule

// File: tb/tb_fp2d_digit_serializer.sv
// Scoreboard bench for fp2d_digit_serializer: expected digits are derived
// arithmetically from each operand when it is accepted.
module tb_fp2d_digit_serializer;

  localparam int FD = 7;
  localparam int FW = 4 * FD;
  localparam int SW = 1 + 12 + FW + 6 + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [8:0]    in_left_digit;
  logic [22:0]   in_right_digit;
  logic          in_sign;
  logic [5:0]    in_exp_10;
  logic          in_sign_exp_10;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [11:0]   out_int_bcd;
  logic [FW-1:0] out_frac_bcd;
  logic [5:0]    out_exp_10;
  logic          out_sign_exp_10;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [SW-1:0] sb_q[$];

  fp2d_digit_serializer #(.FRAC_DIGITS(FD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_left_digit   (in_left_digit),
    .in_right_digit  (in_right_digit),
    .in_sign         (in_sign),
    .in_exp_10       (in_exp_10),
    .in_sign_exp_10  (in_sign_exp_10),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sign        (out_sign),
    .out_int_bcd     (out_int_bcd),
    .out_frac_bcd    (out_frac_bcd),
    .out_exp_10      (out_exp_10),
    .out_sign_exp_10 (out_sign_exp_10),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  wire [SW-1:0] snap = {out_sign, out_int_bcd, out_frac_bcd, out_exp_10, out_sign_exp_10};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Truncated decimal digits: floor(right * 10^FD / 2^23), written out in BCD.
  function automatic logic [SW-1:0] model(input logic [8:0] l, input logic [22:0] r,
                                          input logic s, input logic [5:0] e, input logic se);
    logic [11:0]   ib;
    logic [FW-1:0] fb;
    longint        n;
    longint        scale;
    scale = 1;
    for (int d = 0; d < FD; d++) scale = scale * 10;
    ib = '0;
    n  = longint'(l);
    for (int d = 0; d < 3; d++) begin
      ib[4*d +: 4] = 4'(n % 10);
      n = n / 10;
    end
    fb = '0;
    n  = (longint'(r) * scale) >>> 23;
    for (int d = 0; d < FD; d++) begin
      fb[4*d +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return {s, ib, fb, e, se};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_outputs"}, 64'(snap), 64'd0);
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_op(input logic [8:0] l, input logic [22:0] r, input logic s,
                        input logic [5:0] e, input logic se, input bit pulse, input int hold);
    int            cycles;
    bit            got;
    logic [SW-1:0] exp_v;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_left_digit  = l;
    in_right_digit = r;
    in_sign        = s;
    in_exp_10      = e;
    in_sign_exp_10 = se;
    in_valid       = 1'b1;
    sb_q.push_back(model(l, r, s, e, se));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (pulse && cycles == 3) begin
        in_left_digit  = 9'd99;
        in_right_digit = 23'h123456;
        in_sign        = ~s;
        in_exp_10      = ~e;
        in_valid       = 1'b1;
      end
      if (pulse && cycles == 4) in_valid = 1'b0;
      if (out_valid) got = 1'b1;
    end
    if (!got) check("out_valid_timeout", 64'd0, 64'd1);
    check("latency", 64'(cycles), 64'(9 + FD));
    exp_v = sb_q.pop_front();
    check("result", 64'(snap), 64'(exp_v));
    check("in_ready_done", 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_result", 64'(snap), 64'(exp_v));
      check("hold_valid", 64'({out_valid, in_ready}), 64'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_pop", 64'(in_ready), 64'd1);
    check("valid_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    in_left_digit  = '0;
    in_right_digit = '0;
    in_sign        = 1'b0;
    in_exp_10      = '0;
    in_sign_exp_10 = 1'b0;
    #12;
    check_reset_state("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(9'd1,   23'h000000, 1'b0, 6'd0, 1'b0, 1'b0, 0);
    run_op(9'd3,   23'h400000, 1'b0, 6'd0, 1'b0, 1'b0, 0);
    run_op(9'd511, 23'h200000, 1'b0, 6'd0, 1'b0, 1'b0, 0);
    run_op(9'd0,   23'h7FFFFF, 1'b0, 6'd0, 1'b0, 1'b0, 0);
    run_op(9'd42,  23'h0ABCDE, 1'b1, 6'd9, 1'b1, 1'b1, 0);
    run_op(9'd123, 23'h1ABCDE, 1'b0, 6'd3, 1'b0, 1'b0, 20);
    for (int k = 0; k < 4; k++) begin
      run_op(9'($urandom_range(0, 511)), 23'($urandom), 1'($urandom),
             6'($urandom), 1'($urandom), 1'b0, 0);
    end

    // Reset while the fraction digits are being produced
    in_left_digit  = 9'd255;
    in_right_digit = 23'h555555;
    in_sign        = 1'b1;
    in_exp_10      = 6'd17;
    in_sign_exp_10 = 1'b1;
    in_valid       = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("no_valid_after_reset", 64'(out_valid), 64'd0);

    run_op(9'd7, 23'h600000, 1'b0, 6'd0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
